// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute program-counter sequencer.
// It walks IDLE -> FETCH -> EXEC -> (FETCH | HALT). The PC, the fetched
// instruction and the retired count are registered. imem_req and halted
// decode directly from the state register.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_exec_done,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_target,
    input  logic        i_halt_req,
    output logic [31:0] o_pc_out,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_instr,
    output logic        o_instr_valid,
    output logic        o_halted,
    output logic        o_misalign,
    output logic [31:0] o_retired
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic        r_misalign;
    logic [31:0] r_retired;

    logic        w_ack_taken;
    logic        w_done_taken;
    logic        w_bad_target;
    logic [31:0] w_next_pc;

    // Handshakes count only in the state that owns them. Inputs in any other state are ignored.
    assign w_ack_taken  = (r_state == S_FETCH) && i_imem_ack;
    assign w_done_taken = (r_state == S_EXEC) && i_exec_done;
    assign w_bad_target = i_redirect_valid && (i_redirect_target[1:0] != 2'b00);
    assign w_next_pc    = i_redirect_valid ? i_redirect_target : (r_pc + PC_STEP);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic. A misaligned redirect wins over halt_req, and halt_req wins over a normal fetch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_FETCH;
            S_FETCH: if (i_imem_ack) w_state_nxt = S_EXEC;
            S_EXEC: begin
                if (i_exec_done) begin
                    if (w_bad_target || i_halt_req) w_state_nxt = S_HALT;
                    else                            w_state_nxt = S_FETCH;
                end
            end
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers: PC, latched instruction, valid pulse, sticky misalign flag and retire counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0;
            r_instr_valid <= 1'b0;
            r_misalign    <= 1'b0;
            r_retired     <= 32'h0;
        end else begin
            r_instr_valid <= w_ack_taken;
            if (w_ack_taken) r_instr <= i_imem_rdata;
            if (w_done_taken) begin
                r_retired <= r_retired + 32'd1;
                // A misaligned redirect keeps the PC of the offending instruction.
                if (w_bad_target) r_misalign <= 1'b1;
                else              r_pc       <= w_next_pc;
            end
        end
    end

    assign o_pc_out      = r_pc;
    assign o_imem_addr   = r_pc;
    assign o_imem_req    = (r_state == S_FETCH);
    assign o_halted      = (r_state == S_HALT);
    assign o_instr       = r_instr;
    assign o_instr_valid = r_instr_valid;
    assign o_misalign    = r_misalign;
    assign o_retired     = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: a directed sequence for the documented corner cases, then a
// randomized run. Every cycle is checked against a phase-level reference model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, imem_ack, exec_done, redirect_valid, halt_req;
    logic [31:0] imem_rdata, redirect_target;
    logic [31:0] pc_out, imem_addr, instr, retired;
    logic        imem_req, instr_valid, halted, misalign;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_imem_ack(imem_ack),
        .i_imem_rdata(imem_rdata), .i_exec_done(exec_done),
        .i_redirect_valid(redirect_valid), .i_redirect_target(redirect_target),
        .i_halt_req(halt_req), .o_pc_out(pc_out), .o_imem_req(imem_req),
        .o_imem_addr(imem_addr), .o_instr(instr), .o_instr_valid(instr_valid),
        .o_halted(halted), .o_misalign(misalign), .o_retired(retired)
    );

    // Reference model. Its phase is held in a string. Its values are computed from the sequencing rules.
    string       m_phase = "idle";
    logic [31:0] m_pc = 32'h0, m_instr = 32'h0, m_ret = 32'h0;
    bit          m_iv = 0, m_mis = 0;

    task automatic model_step();
        logic [31:0] tgt;
        m_iv = 0;
        if (rst) begin
            m_phase = "idle"; m_pc = 32'h0; m_instr = 32'h0; m_ret = 32'h0; m_mis = 0;
        end else if (m_phase == "idle") begin
            if (start) m_phase = "fetch";
        end else if (m_phase == "fetch") begin
            if (imem_ack) begin
                m_instr = imem_rdata; m_iv = 1; m_phase = "exec";
            end
        end else if (m_phase == "exec" && exec_done) begin
            m_ret = m_ret + 1;
            tgt = redirect_valid ? redirect_target : m_pc + 32'd4;
            if (redirect_valid && (redirect_target % 4) != 0) begin
                m_mis = 1; m_phase = "halt";
            end else begin
                m_pc = tgt;
                m_phase = halt_req ? "halt" : "fetch";
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock. The model is updated from the inputs the DUT samples at that edge.
    // All outputs are checked 1 time unit after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("pc_out",      pc_out,              m_pc);
        check("imem_addr",   imem_addr,           m_pc);
        check("imem_req",    {31'h0, imem_req},   {31'h0, m_phase == "fetch"});
        check("halted",      {31'h0, halted},     {31'h0, m_phase == "halt"});
        check("instr",       instr,               m_instr);
        check("instr_valid", {31'h0, instr_valid}, {31'h0, m_iv});
        check("misalign",    {31'h0, misalign},   {31'h0, m_mis});
        check("retired",     retired,             m_ret);
    endtask

    task automatic quiet();
        rst = 0; start = 0; imem_ack = 0; exec_done = 0;
        redirect_valid = 0; halt_req = 0;
        imem_rdata = 32'h0; redirect_target = 32'h0;
    endtask

    task automatic fetch_ok(input logic [31:0] w);
        quiet(); imem_ack = 1; imem_rdata = w; tick(); quiet();
    endtask

    task automatic done(input bit rv, input logic [31:0] t, input bit h);
        quiet(); exec_done = 1; redirect_valid = rv; redirect_target = t; halt_req = h;
        tick(); quiet();
    endtask

    initial begin
        quiet();
        rst = 1; tick(); tick();
        quiet(); tick();

        // start at c1; fetch at c2..c3; ack at c3; instruction latched at c4
        start = 1; tick();
        quiet(); tick();
        fetch_ok(32'hDEAD_BEEF);
        tick();
        // spurious start/ack while in EXEC
        start = 1; imem_ack = 1; imem_rdata = 32'h1234_5678; tick(); quiet();

        // move to 0x10, then step sequentially, then take a redirect
        done(1, 32'h10, 0);  fetch_ok(32'hA0);
        done(0, 32'h0, 0);   fetch_ok(32'hA1);
        done(1, 32'h40, 0);  fetch_ok(32'hA2);
        // PC wraps from the top of the address space to 0
        done(1, 32'hFFFF_FFFC, 0); fetch_ok(32'hA3);
        done(0, 32'h0, 0);
        tick();
        // reset in FETCH coincident with ack
        imem_ack = 1; imem_rdata = 32'hCAFE_F00D; rst = 1; tick(); quiet(); tick();

        // misaligned redirect together with halt_req
        start = 1; tick(); quiet();
        fetch_ok(32'hB0);
        done(1, 32'h41, 1);
        // spurious inputs in HALT
        start = 1; tick(); quiet();
        imem_ack = 1; imem_rdata = 32'h5; tick(); quiet();
        done(1, 32'h80, 0);
        done(0, 32'h0, 1);

        // aligned halt_req
        rst = 1; tick(); quiet();
        start = 1; tick(); quiet();
        fetch_ok(32'hC0);
        done(0, 32'h0, 1);
        tick();

        // randomized phase
        rst = 1; tick(); quiet();
        for (int i = 0; i < 3000; i++) begin
            rst             = ($urandom_range(0, 79) == 0);
            start           = ($urandom_range(0, 1) == 0);
            imem_ack        = ($urandom_range(0, 2) == 0);
            imem_rdata      = $urandom;
            exec_done       = ($urandom_range(0, 2) == 0);
            redirect_valid  = ($urandom_range(0, 1) == 0);
            halt_req        = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0: redirect_target = $urandom;
                1: redirect_target = 32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2);
                default: redirect_target = $urandom & 32'hFFFF_FFFC;
            endcase
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
